// File: rtl/fsic_wb_cfg_bridge.sv
// Wishbone slave front end of FSIC: window decode and WB-classic to config request/response bus.
// Optional bus timeout enabled by defining FSIC_WB_TIMEOUT_EN.
module fsic_wb_cfg_bridge #(
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
   parameter logic [31:0] WIN_MASK    = 32'hFFF0_0000,
   parameter int unsigned ADDR_W      = 15,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic              wb_clk,
   input  logic              wb_rst,
   input  logic [31:0]       wbs_adr,
   input  logic [31:0]       wbs_wdata,
   input  logic [3:0]        wbs_sel,
   input  logic              wbs_cyc,
   input  logic              wbs_stb,
   input  logic              wbs_we,
   output logic              wbs_ack,
   output logic [31:0]       wbs_rdata,
   output logic              cfg_req,
   output logic              cfg_we,
   output logic [ADDR_W-1:0] cfg_addr,
   output logic [31:0]       cfg_wdata,
   output logic [3:0]        cfg_be,
   input  logic              cfg_gnt,
   input  logic              cfg_rvalid,
   input  logic [31:0]       cfg_rdata,
   output logic              bus_err
);

   typedef enum logic [2:0] {IDLE, REQ, RDWAIT, ACK, DRAIN} state_t;

   state_t state;
   logic   wb_req;
   logic   win_hit;

   // !wbs_ack keeps the still-asserted stb of the just-acked cycle from restarting a transfer
   assign wb_req  = wbs_cyc & wbs_stb & ~wbs_ack;
   assign win_hit = ((wbs_adr & WIN_MASK) == BASE_ADDR);

`ifdef FSIC_WB_TIMEOUT_EN
   localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

   logic [15:0] to_cnt;
   logic        to_hit;

   assign to_hit = (to_cnt == TO_LIM);

   // REQ is only entered from IDLE, so clearing in IDLE gives a fresh count per request
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         to_cnt <= '0;
      end else if (state == IDLE) begin
         to_cnt <= '0;
      end else if ((state == REQ || state == RDWAIT || state == DRAIN) && !to_hit) begin
         to_cnt <= to_cnt + 16'd1;
      end
   end
`else
   logic unused_timeout;

   assign unused_timeout = ^TIMEOUT_CYC;
   assign bus_err        = 1'b0;
`endif

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         state     <= IDLE;
         wbs_ack   <= 1'b0;
         wbs_rdata <= '0;
         cfg_req   <= 1'b0;
         cfg_we    <= 1'b0;
         cfg_addr  <= '0;
         cfg_wdata <= '0;
         cfg_be    <= '0;
`ifdef FSIC_WB_TIMEOUT_EN
         bus_err   <= 1'b0;
`endif
      end else begin
         wbs_ack <= 1'b0;
         case (state)
            IDLE: begin
               wbs_rdata <= '0;
               if (wb_req) begin
                  if (win_hit) begin
                     cfg_req   <= 1'b1;
                     cfg_we    <= wbs_we;
                     cfg_addr  <= wbs_adr[ADDR_W-1:0];
                     cfg_wdata <= wbs_wdata;
                     cfg_be    <= wbs_sel;
                     state     <= REQ;
                  end else begin
                     state <= ACK;
                  end
               end
            end
            REQ: begin
               if (cfg_gnt) begin
                  cfg_req <= 1'b0;
                  if (cfg_we) begin
                     state <= ACK;
                  end else if (cfg_rvalid) begin
                     wbs_rdata <= cfg_rdata;
                     state     <= ACK;
                  end else begin
                     state <= RDWAIT;
                  end
               end else if (!wbs_cyc) begin
                  cfg_req <= 1'b0;
                  state   <= IDLE;
               end
`ifdef FSIC_WB_TIMEOUT_EN
               else if (to_hit) begin
                  cfg_req   <= 1'b0;
                  bus_err   <= 1'b1;
                  wbs_rdata <= 32'hDEAD_BEEF;
                  state     <= ACK;
               end
`endif
            end
            RDWAIT: begin
               // an aborted read still owes a response; a coincident one is simply dropped
               if (!wbs_cyc) begin
                  state <= cfg_rvalid ? IDLE : DRAIN;
               end else if (cfg_rvalid) begin
                  wbs_rdata <= cfg_rdata;
                  state     <= ACK;
               end
`ifdef FSIC_WB_TIMEOUT_EN
               else if (to_hit) begin
                  bus_err   <= 1'b1;
                  wbs_rdata <= 32'hDEAD_BEEF;
                  state     <= ACK;
               end
`endif
            end
            ACK: begin
               wbs_ack <= 1'b1;
               state   <= IDLE;
            end
            DRAIN: begin
               if (cfg_rvalid) begin
                  state <= IDLE;
               end
`ifdef FSIC_WB_TIMEOUT_EN
               else if (to_hit) begin
                  state <= IDLE;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fsic_wb_cfg_bridge.sv
// Scoreboard bench for fsic_wb_cfg_bridge: WB acks and config grants are checked against queued expectations.
module tb_fsic_wb_cfg_bridge;

   logic        wb_clk = 1'b0;
   logic        wb_rst;
   logic [31:0] wbs_adr, wbs_wdata;
   logic [3:0]  wbs_sel;
   logic        wbs_cyc, wbs_stb, wbs_we;
   logic        wbs_ack;
   logic [31:0] wbs_rdata;
   logic        cfg_req, cfg_we;
   logic [14:0] cfg_addr;
   logic [31:0] cfg_wdata;
   logic [3:0]  cfg_be;
   logic        cfg_gnt, cfg_rvalid;
   logic [31:0] cfg_rdata;
   logic        bus_err;

   fsic_wb_cfg_bridge #(
      .BASE_ADDR  (32'h3000_0000),
      .WIN_MASK   (32'hFFF0_0000),
      .ADDR_W     (15),
      .TIMEOUT_CYC(255)
   ) dut (
      .wb_clk    (wb_clk),
      .wb_rst    (wb_rst),
      .wbs_adr   (wbs_adr),
      .wbs_wdata (wbs_wdata),
      .wbs_sel   (wbs_sel),
      .wbs_cyc   (wbs_cyc),
      .wbs_stb   (wbs_stb),
      .wbs_we    (wbs_we),
      .wbs_ack   (wbs_ack),
      .wbs_rdata (wbs_rdata),
      .cfg_req   (cfg_req),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .cfg_be    (cfg_be),
      .cfg_gnt   (cfg_gnt),
      .cfg_rvalid(cfg_rvalid),
      .cfg_rdata (cfg_rdata),
      .bus_err   (bus_err)
   );

   always #5 wb_clk = ~wb_clk;

   typedef struct {
      logic [31:0] rdata;
      int          at;
   } ack_exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          len;
   } cfg_exp_t;

   ack_exp_t ack_q[$];
   cfg_exp_t cfg_q[$];
   ack_exp_t ae;
   cfg_exp_t ce;

   int total = 0;
   int bad   = 0;
   int cyc_n = 0;

   always @(posedge wb_clk) cyc_n <= cyc_n + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   // config slave model: grant after gnt_dly waiting cycles, read data rv_dly cycles after the grant
   int          gnt_dly = 0, rv_dly = 0, wait_cnt = 0, rv_cnt = 0;
   logic [31:0] rv_data = '0;
   bit          rv_en = 1'b1, rv_pend = 1'b0, force_rv = 1'b0;

   initial begin
      cfg_gnt = 1'b0; cfg_rvalid = 1'b0; cfg_rdata = '0;
      forever begin
         @(posedge wb_clk); #2;
         cfg_gnt = 1'b0; cfg_rvalid = 1'b0;
         if (wb_rst) begin
            rv_pend = 1'b0; wait_cnt = 0;
         end else begin
            if (force_rv) begin
               cfg_rvalid = 1'b1; cfg_rdata = 32'hFACE_0FF0; force_rv = 1'b0;
            end
            if (rv_pend) begin
               rv_cnt--;
               if (rv_cnt <= 0) begin
                  cfg_rvalid = 1'b1; cfg_rdata = rv_data; rv_pend = 1'b0;
               end
            end
            if (cfg_req) begin
               if (wait_cnt >= gnt_dly) begin
                  cfg_gnt = 1'b1; wait_cnt = 0;
                  if (!cfg_we && rv_en) begin
                     if (rv_dly == 0) begin
                        cfg_rvalid = 1'b1; cfg_rdata = rv_data;
                     end else begin
                        rv_pend = 1'b1; rv_cnt = rv_dly;
                     end
                  end
               end else begin
                  wait_cnt++;
               end
            end else begin
               wait_cnt = 0;
            end
         end
      end
   end

   // monitor: pops expectations when the DUT acks or a config request is granted
   bit          prev_ack = 1'b0;
   int          req_len = 0;
   logic [31:0] prev_addr, prev_wdata, prev_ctl;

   always @(negedge wb_clk) begin
      if (wb_rst) begin
         prev_ack = 1'b0;
         req_len  = 0;
      end else begin
         if (prev_ack) begin
            chk("rdata_cleared_after_ack", wbs_rdata, 32'h0);
            chk("ack_single_pulse", {31'b0, wbs_ack}, 32'h0);
         end
         if (wbs_ack) begin
            if (ack_q.size() == 0) begin
               chk("spurious_ack", {31'b0, wbs_ack}, 32'h0);
            end else begin
               ae = ack_q.pop_front();
               chk("ack_rdata", wbs_rdata, ae.rdata);
               chk("ack_cycle", cyc_n, ae.at);
            end
         end
         prev_ack = wbs_ack;

         if (cfg_req) begin
            if (req_len > 0) begin
               chk("req_hold_addr", {17'b0, cfg_addr}, prev_addr);
               chk("req_hold_wdata", cfg_wdata, prev_wdata);
               chk("req_hold_ctl", {27'b0, cfg_we, cfg_be}, prev_ctl);
            end
            req_len++;
            prev_addr  = {17'b0, cfg_addr};
            prev_wdata = cfg_wdata;
            prev_ctl   = {27'b0, cfg_we, cfg_be};
            if (cfg_gnt) begin
               if (cfg_q.size() == 0) begin
                  chk("spurious_cfg_req", {31'b0, cfg_req}, 32'h0);
               end else begin
                  ce = cfg_q.pop_front();
                  chk("cfg_we", {31'b0, cfg_we}, {31'b0, ce.we});
                  chk("cfg_addr", {17'b0, cfg_addr}, ce.addr);
                  chk("cfg_wdata", cfg_wdata, ce.wdata);
                  chk("cfg_be", {28'b0, cfg_be}, {28'b0, ce.be});
                  chk("cfg_req_len", req_len, ce.len);
               end
               req_len = 0;
            end
         end else begin
            req_len = 0;
         end
      end
   end

   task automatic push_cfg(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be, input int len);
      cfg_q.push_back('{we, addr, wd, be, len});
   endtask

   task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] sel);
      wbs_we = we; wbs_adr = adr; wbs_wdata = wd; wbs_sel = sel;
      wbs_cyc = 1'b1; wbs_stb = 1'b1;
   endtask

   task automatic release_bus();
      wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
   endtask

   // one WB classic cycle; ack is expected exp_lat cycles after stb is first driven
   task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] sel,
                          input logic [31:0] exp_rdata, input int exp_lat, input int max_wait);
      int n;
      @(posedge wb_clk); #1;
      ack_q.push_back('{exp_rdata, cyc_n + exp_lat});
      drive(we, adr, wd, sel);
      n = 0;
      while (!wbs_ack && n < max_wait) begin
         @(posedge wb_clk); #1;
         n++;
      end
      if (!wbs_ack) begin
         chk("ack_wait_expired", {31'b0, wbs_ack}, 32'h1);
         ack_q.delete();
      end
      @(posedge wb_clk); #1;
      release_bus();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ack"}, {31'b0, wbs_ack}, 32'h0);
      chk({tag, "_rdata"}, wbs_rdata, 32'h0);
      chk({tag, "_cfg_req"}, {31'b0, cfg_req}, 32'h0);
      chk({tag, "_cfg_we"}, {31'b0, cfg_we}, 32'h0);
      chk({tag, "_cfg_addr"}, {17'b0, cfg_addr}, 32'h0);
      chk({tag, "_cfg_wdata"}, cfg_wdata, 32'h0);
      chk({tag, "_cfg_be"}, {28'b0, cfg_be}, 32'h0);
      chk({tag, "_bus_err"}, {31'b0, bus_err}, 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acks;
      wb_rst = 1'b1;
      wbs_adr = '0; wbs_wdata = '0; wbs_sel = '0;
      wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
      repeat (3) @(posedge wb_clk);
      #1;
      chk_all_zero("reset");
      wb_rst = 1'b0;

      // hit write, immediate grant
      gnt_dly = 0;
      push_cfg(1'b1, 32'h1004, 32'hA5A5_0001, 4'hF, 1);
      wb_xfer(1'b1, 32'h3000_1004, 32'hA5A5_0001, 4'hF, 32'h0, 3, 50);

      // hit read, grant after 2 waits, data 4 cycles after grant
      gnt_dly = 2; rv_dly = 4; rv_data = 32'h1234_5678;
      push_cfg(1'b0, 32'h0208, 32'h0, 4'hF, 3);
      wb_xfer(1'b0, 32'h3000_0208, 32'h0, 4'hF, 32'h1234_5678, 9, 50);

      // read whose data arrives together with the grant
      gnt_dly = 1; rv_dly = 0; rv_data = 32'hCAFE_0001;
      push_cfg(1'b0, 32'h0100, 32'h0, 4'hF, 2);
      wb_xfer(1'b0, 32'h3000_0100, 32'h0, 4'hF, 32'hCAFE_0001, 4, 50);

      // top of window, partial byte enables; address truncated to 15 bits
      gnt_dly = 0;
      push_cfg(1'b1, 32'h7FFC, 32'h0BAD_F00D, 4'h3, 1);
      wb_xfer(1'b1, 32'h300F_FFFC, 32'h0BAD_F00D, 4'h3, 32'h0, 3, 50);

      // misses: below and just above the window
      wb_xfer(1'b0, 32'h2600_0000, 32'h0, 4'hF, 32'h0, 2, 50);
      wb_xfer(1'b1, 32'h3010_0000, 32'h5555_AAAA, 4'hF, 32'h0, 2, 50);

      // abort while waiting for grant
      gnt_dly = 30;
      @(posedge wb_clk); #1;
      drive(1'b1, 32'h3000_0020, 32'h1111_2222, 4'hF);
      repeat (3) @(posedge wb_clk);
      #1;
      release_bus();
      repeat (2) @(posedge wb_clk);
      #1;
      chk("abort_req_drops_cfg_req", {31'b0, cfg_req}, 32'h0);
      repeat (3) @(posedge wb_clk);

      // abort during read wait, stale data must not leak into the next read
      gnt_dly = 0; rv_dly = 8; rv_data = 32'hBAD0_BAD0;
      push_cfg(1'b0, 32'h0010, 32'h0, 4'hF, 1);
      @(posedge wb_clk); #1;
      drive(1'b0, 32'h3000_0010, 32'h0, 4'hF);
      repeat (3) @(posedge wb_clk);
      #1;
      release_bus();
      repeat (15) @(posedge wb_clk);
      rv_dly = 1; rv_data = 32'h0000_C0DE;
      push_cfg(1'b0, 32'h0014, 32'h0, 4'hF, 1);
      wb_xfer(1'b0, 32'h3000_0014, 32'h0, 4'hF, 32'h0000_C0DE, 4, 50);

      // read that never gets data
      rv_en = 1'b0; gnt_dly = 0;
      push_cfg(1'b0, 32'h0040, 32'h0, 4'hF, 1);
`ifdef FSIC_WB_TIMEOUT_EN
      wb_xfer(1'b0, 32'h3000_0040, 32'h0, 4'hF, 32'hDEAD_BEEF, 258, 400);
      chk("timeout_bus_err", {31'b0, bus_err}, 32'h1);
      force_rv = 1'b1;
      repeat (5) @(posedge wb_clk);
`else
      @(posedge wb_clk); #1;
      drive(1'b0, 32'h3000_0040, 32'h0, 4'hF);
      acks = 0;
      repeat (1000) begin
         @(posedge wb_clk); #1;
         if (wbs_ack) acks++;
      end
      chk("no_timeout_ack_count", acks, 32'h0);
      chk("no_timeout_bus_err", {31'b0, bus_err}, 32'h0);
      release_bus();
      repeat (2) @(posedge wb_clk);
      force_rv = 1'b1;
      repeat (5) @(posedge wb_clk);
`endif
      rv_en = 1'b1;
      push_cfg(1'b1, 32'h0044, 32'h0000_0044, 4'hF, 1);
      wb_xfer(1'b1, 32'h3000_0044, 32'h0000_0044, 4'hF, 32'h0, 3, 50);
`ifdef FSIC_WB_TIMEOUT_EN
      chk("bus_err_sticky", {31'b0, bus_err}, 32'h1);
`endif

      // asynchronous reset in the middle of a request
      gnt_dly = 50;
      @(posedge wb_clk); #1;
      drive(1'b1, 32'h3000_0030, 32'h3030_3030, 4'hC);
      repeat (2) @(posedge wb_clk);
      #1;
      chk("pre_reset_cfg_req", {31'b0, cfg_req}, 32'h1);
      #2 wb_rst = 1'b1;
      #1;
      chk_all_zero("async_reset");
      release_bus();
      @(posedge wb_clk); #1;
      wb_rst = 1'b0;
      gnt_dly = 0;
      push_cfg(1'b1, 32'h0034, 32'h3434_3434, 4'hF, 1);
      wb_xfer(1'b1, 32'h3000_0034, 32'h3434_3434, 4'hF, 32'h0, 3, 50);

      repeat (5) @(posedge wb_clk);
      #1;
      chk("ack_queue_drained", ack_q.size(), 32'h0);
      chk("cfg_queue_drained", cfg_q.size(), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fsic_wb_cfg_bridge.md
Name: fsic_wb_cfg_bridge

Overview:
- Wishbone slave front end of the FSIC core. It sits directly downstream of the Caravel management-SoC Wishbone port that the user project wrapper passes through.
- Decodes the FSIC address window and converts each WB classic cycle into one transfer on the internal config request/response bus, which feeds the FSIC CSR and AXI-Lite fabric.
- Generates wbs_ack and wbs_rdata back to the management SoC.

Parameters:
- BASE_ADDR, 32'h3000_0000, base of the FSIC window.
- WIN_MASK, 32'hFFF0_0000, bits compared against BASE_ADDR for the window hit.
- ADDR_W, 15, width of the forwarded byte address, taken from wbs_adr[ADDR_W-1:0].
- TIMEOUT_CYC, 255, cycles without a response before the bus error completes the cycle (optional feature only).

Ports:
- wb_clk  in  1  single clock for the whole block.
- wb_rst  in  1  asynchronous, active-high reset.
- wbs_adr  in  32  WB address.
- wbs_wdata  in  32  WB write data.
- wbs_sel  in  4  WB byte selects.
- wbs_cyc  in  1  WB cycle.
- wbs_stb  in  1  WB strobe.
- wbs_we  in  1  WB write enable.
- wbs_ack  out  1  WB acknowledge, one-cycle pulse.
- wbs_rdata  out  32  WB read data, valid while wbs_ack=1.
- cfg_req  out  1  config request valid.
- cfg_we  out  1  config write (1) or read (0).
- cfg_addr  out  ADDR_W  config byte address.
- cfg_wdata  out  32  config write data.
- cfg_be  out  4  config byte enables.
- cfg_gnt  in  1  downstream accepts the request this cycle.
- cfg_rvalid  in  1  read data valid, one-cycle pulse.
- cfg_rdata  in  32  read data.
- bus_err  out  1  sticky timeout flag, cleared only by reset.

Behaviour:
- Reset values: wbs_ack=0, wbs_rdata=0, cfg_req=0, cfg_we=0, cfg_addr=0, cfg_wdata=0, cfg_be=0, bus_err=0; FSM=IDLE.
- Reset is asynchronous assert and takes effect mid-transfer. An outstanding read response arriving after reset is ignored.
- FSM states: IDLE, REQ, RDWAIT, ACK, DRAIN.
- IDLE, on cyc&stb&!wbs_ack:
  - Window miss ((wbs_adr&WIN_MASK)!=BASE_ADDR): go to ACK with wbs_rdata=0; writes are dropped.
  - Window hit: register we, adr[ADDR_W-1:0], wdata and sel into the cfg_* outputs, assert cfg_req, go to REQ.
- REQ:
  - cfg_req and the cfg_* payload are held stable until cfg_gnt=1.
  - On cfg_gnt with a write: deassert cfg_req, go to ACK.
  - On cfg_gnt with a read: deassert cfg_req, go to RDWAIT.
  - cfg_gnt is sampled the same cycle cfg_req is high, so the minimum request length is 1 cycle.
- RDWAIT: on cfg_rvalid, capture cfg_rdata into wbs_rdata and go to ACK. If cfg_rvalid arrives in the same cycle as cfg_gnt, REQ goes straight to ACK with the data captured.
- ACK:
  - wbs_ack=1 for exactly one cycle, then IDLE. wbs_rdata is cleared to 0 on the cycle after ack.
  - Because of the !wbs_ack qualifier, a new request is taken no earlier than the cycle after ack.
- Latency from the stb sample edge to ack: miss 2 cycles; hit write with immediate gnt 3 cycles; hit read = 3 + read-data delay.
- Master abort (cyc falls before ack):
  - In REQ before gnt: drop cfg_req, return to IDLE, no ack.
  - In RDWAIT: go to DRAIN, wait for cfg_rvalid, discard the data, return to IDLE, no ack.
  - In ACK: the ack still pulses; the WB master ignores it.
- cfg_rvalid outside RDWAIT and DRAIN is ignored.

Optional Feature:
- Macro: FSIC_WB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to REQ and counts in REQ and RDWAIT.
  - When it reaches TIMEOUT_CYC: set bus_err, drop cfg_req, load wbs_rdata=32'hDEAD_BEEF, go to ACK.
  - A late cfg_rvalid after a read timeout is ignored.
  - DRAIN also times out, silently, back to IDLE.
- Not defined: there is no counter, bus_err is tied to 0, and the FSM waits indefinitely.

Test Plan:
- Hit write: adr=0x3000_1004, wdata=0xA5A5_0001, sel=0xF, cfg_gnt tied high -> cfg_req 1 cycle with cfg_addr=0x1004 and cfg_be=0xF; wbs_ack single pulse 3 cycles after stb.
- Hit read, gnt delayed 2 cycles, cfg_rvalid 4 cycles after gnt with cfg_rdata=0x1234_5678 -> cfg_req held 3 cycles with a stable payload; wbs_ack pulses with wbs_rdata=0x1234_5678; wbs_rdata returns to 0 the next cycle.
- Miss: read adr=0x2600_0000 -> no cfg_req; wbs_ack after 2 cycles with wbs_rdata=0. Miss write -> ack, no cfg_req.
- Abort: cyc dropped during RDWAIT, then a late rvalid, then a new read -> no ack for the aborted read; the new read returns its own data, not the stale data.
- Timeout (macro on, TIMEOUT_CYC=255): read with no rvalid -> ack after ~256 cycles with 0xDEAD_BEEF and bus_err=1. Macro off -> no ack after 1000 cycles.
- Reset mid-REQ: assert wb_rst asynchronously -> all outputs 0 immediately; after release, a subsequent write completes normally.
